dmem_arbiter: RTL and testbench

Shares the single data-memory port between the MIPS pipeline's MEM stage (CPU requester) and an external loader/debug requester (EXT). Sits between the mips_pipeline data interface and data_mem, and models a data memory with MEM_LAT cycles of access latency. Stalls the pipeline while a CPU access is pending. Sequences each access so data_mem sees exactly one write strobe per store.

---
 rtl/dmem_arbiter_if.sv | 29 ++
 rtl/dmem_arbiter.sv | 71 +++++++
 tb/tb_dmem_arbiter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: CPU, EXT and data_mem signal bundle for dmem_arbiter.
// slave is the arbiter's view; master is the surrounding system's view.
interface dmem_arbiter_if;
  logic [31:0] cpu_adr;
  logic [31:0] cpu_wdata;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        ext_req;
  logic        ext_wr;
  logic [31:0] ext_adr;
  logic [31:0] ext_wdata;
  logic        ext_ack;
  logic [31:0] ext_rdata;
  logic [31:0] mem_adr;
  logic [31:0] mem_wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_rdata;
  modport slave (
    input  cpu_adr, cpu_wdata, cpu_rd, cpu_wr, ext_req, ext_wr, ext_adr, ext_wdata, mem_rdata,
    output cpu_rdata, cpu_stall, ext_ack, ext_rdata, mem_adr, mem_wdata, mem_rd, mem_wr
  );
  modport master (
    output cpu_adr, cpu_wdata, cpu_rd, cpu_wr, ext_req, ext_wr, ext_adr, ext_wdata, mem_rdata,
    input  cpu_rdata, cpu_stall, ext_ack, ext_rdata, mem_adr, mem_wdata, mem_rd, mem_wr
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between the CPU MEM stage and an EXT requester.
// Define ARB_ROUND_ROBIN_EN for round-robin on contention; default is fixed CPU priority.
module dmem_arbiter #(
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  dmem_arbiter_if.slave bus
);
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_owner_cpu;
  logic             r_wr;
  logic [31:0]      r_adr;
  logic [31:0]      r_wdata;
  logic [31:0]      r_ext_rdata;
  logic             w_cpu_req;
  logic             w_grant_cpu;
  logic             w_done;
  logic             w_cpu_done;
  logic             w_ext_done;
  assign w_cpu_req  = bus.cpu_rd | bus.cpu_wr;
  assign w_done     = (r_state == ACCESS) && (r_cnt == '0);
  assign w_cpu_done = w_done & r_owner_cpu;
  assign w_ext_done = w_done & ~r_owner_cpu;
`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_cpu;
  // last owner resets to EXT so the first contention still favours the CPU
  assign w_grant_cpu = w_cpu_req & (~bus.ext_req | ~r_last_cpu);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_last_cpu <= 1'b0;
    else if (w_done) r_last_cpu <= r_owner_cpu;
`else
  assign w_grant_cpu = w_cpu_req;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_owner_cpu <= 1'b0;
      r_wr        <= 1'b0;
      r_adr       <= '0;
      r_wdata     <= '0;
      r_ext_rdata <= '0;
    end else if (r_state == IDLE) begin
      if (w_cpu_req | bus.ext_req) begin
        r_state     <= ACCESS;
        r_cnt       <= CNT_W'(MEM_LAT - 1);
        r_owner_cpu <= w_grant_cpu;
        r_wr        <= w_grant_cpu ? bus.cpu_wr    : bus.ext_wr;
        r_adr       <= w_grant_cpu ? bus.cpu_adr   : bus.ext_adr;
        r_wdata     <= w_grant_cpu ? bus.cpu_wdata : bus.ext_wdata;
      end
    end else begin
      if (w_done) r_state <= IDLE;
      else r_cnt <= r_cnt - 1'b1;
      if (w_ext_done & ~r_wr) r_ext_rdata <= bus.mem_rdata;
    end
  end
  // single write strobe per store, only in the completion cycle
  assign bus.mem_adr   = r_adr;
  assign bus.mem_wdata = r_wdata;
  assign bus.mem_rd    = (r_state == ACCESS) & ~r_wr;
  assign bus.mem_wr    = w_done & r_wr;
  assign bus.cpu_stall = w_cpu_req & ~w_cpu_done;
  assign bus.cpu_rdata = w_cpu_done ? bus.mem_rdata : '0;
  assign bus.ext_ack   = w_ext_done;
  assign bus.ext_rdata = r_ext_rdata;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of dmem_arbiter (MEM_LAT=2 and MEM_LAT=1 instances)
// against a word-array data memory.
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  dmem_arbiter_if a();
  dmem_arbiter_if b();
  dmem_arbiter #(.MEM_LAT(2), .CNT_W(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a));
  dmem_arbiter #(.MEM_LAT(1), .CNT_W(4)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b));
  logic [31:0] mem [0:255];
  assign a.mem_rdata = mem[a.mem_adr[7:0]];
  assign b.mem_rdata = mem[b.mem_adr[7:0]];
  always @(posedge clk) if (a.mem_wr) mem[a.mem_adr[7:0]] = a.mem_wdata;
  int n_chk = 0;
  int n_err = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic cpu_op(input logic wr, input logic [31:0] adr, input logic [31:0] d,
                        output int st, output int nwr, output int nrd, output logic [31:0] rd);
    a.cpu_rd = !wr;
    a.cpu_wr = wr;
    a.cpu_adr = adr;
    a.cpu_wdata = d;
    #1;
    st = 0; nwr = 0; nrd = 0;
    while (a.cpu_stall && st < 20) begin
      nwr += int'(a.mem_wr);
      nrd += int'(a.mem_rd);
      st++;
      cyc();
    end
    nwr += int'(a.mem_wr);
    nrd += int'(a.mem_rd);
    rd = a.cpu_rdata;
    a.cpu_rd = 1'b0;
    a.cpu_wr = 1'b0;
    cyc();
  endtask
  task automatic ext_op(input logic wr, input logic [31:0] adr, input logic [31:0] d, output int n);
    a.ext_req = 1'b1;
    a.ext_wr = wr;
    a.ext_adr = adr;
    a.ext_wdata = d;
    #1;
    n = 0;
    while (!a.ext_ack && n < 30) begin
      n++;
      cyc();
    end
    a.ext_req = 1'b0;
    cyc();
  endtask
  int st, nwr, nrd, n, cdone, edone, nc, ne, first;
  logic [31:0] rd;
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h10] = 32'hDEADBEEF;
    {a.cpu_adr, a.cpu_wdata, a.cpu_rd, a.cpu_wr, a.ext_req, a.ext_wr, a.ext_adr, a.ext_wdata} = '0;
    {b.cpu_adr, b.cpu_wdata, b.cpu_rd, b.cpu_wr, b.ext_req, b.ext_wr, b.ext_adr, b.ext_wdata} = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_rd", 32'(a.mem_rd), 0);
    chk("rst_mem_wr", 32'(a.mem_wr), 0);
    chk("rst_mem_adr", a.mem_adr, 0);
    chk("rst_mem_wdata", a.mem_wdata, 0);
    chk("rst_ext_ack", 32'(a.ext_ack), 0);
    chk("rst_ext_rdata", a.ext_rdata, 0);
    chk("rst_cpu_stall", 32'(a.cpu_stall), 0);
    chk("rst_cpu_rdata", a.cpu_rdata, 0);
    rst_n = 1'b1;
    cyc();
    cpu_op(1'b0, 32'h10, 32'h0, st, nwr, nrd, rd);
    chk("ld_stall_cycles", 32'(st), 2);
    chk("ld_rdata", rd, 32'hDEADBEEF);
    chk("ld_no_wr", 32'(nwr), 0);
    chk("ld_rd_cycles", 32'(nrd), 2);
    chk("idle_cpu_rdata", a.cpu_rdata, 0);
    cpu_op(1'b1, 32'h20, 32'h00001234, st, nwr, nrd, rd);
    chk("st_stall_cycles", 32'(st), 2);
    chk("st_wr_pulses", 32'(nwr), 1);
    chk("st_mem_word", mem[8'h20], 32'h00001234);
    chk("idle_adr_hold", a.mem_adr, 32'h20);
    chk("idle_mem_wr", 32'(a.mem_wr), 0);
    ext_op(1'b0, 32'h20, 32'h0, n);
    chk("ext_ld_wait", 32'(n), 2);
    chk("ext_ld_rdata", a.ext_rdata, 32'h00001234);
    chk("ext_ack_pulse", 32'(a.ext_ack), 0);
    a.cpu_rd = 1'b1; a.cpu_adr = 32'h10;
    a.ext_req = 1'b1; a.ext_wr = 1'b1; a.ext_adr = 32'h40; a.ext_wdata = 32'hA5A5A5A5;
    #1;
    cdone = -1; edone = -1; rd = '0;
    for (int c = 0; c < 10; c++) begin
      if (a.cpu_rd && !a.cpu_stall) begin cdone = c; rd = a.cpu_rdata; a.cpu_rd = 1'b0; end
      if (a.ext_ack) begin edone = c; a.ext_req = 1'b0; end
      cyc();
    end
    chk("cont_cpu_done", 32'(cdone), 2);
    chk("cont_cpu_rdata", rd, 32'hDEADBEEF);
    chk("cont_ext_ack", 32'(edone), 5);
    chk("cont_mem_word", mem[8'h40], 32'hA5A5A5A5);
    a.cpu_rd = 1'b1; a.cpu_adr = 32'h10;
    a.ext_req = 1'b1; a.ext_wr = 1'b0; a.ext_adr = 32'h20;
    #1;
    nc = 0; ne = 0; first = -1;
    for (int c = 0; c < 20; c++) begin
      if (!a.cpu_stall) nc++;
      if (a.ext_ack) begin ne++; if (first < 0) first = c; end
      cyc();
    end
`ifdef ARB_ROUND_ROBIN_EN
    chk("rr_first_ack", 32'(first), 5);
    chk("rr_ext_grants", 32'(ne), 3);
    chk("rr_cpu_grants", 32'(nc), 3);
`else
    chk("prio_ext_acks", 32'(ne), 0);
    chk("prio_cpu_grants", 32'(nc), 6);
`endif
    a.cpu_rd = 1'b0;
    a.ext_req = 1'b0;
    repeat (3) cyc();
    chk("drain_idle", 32'(a.mem_rd), 0);
    a.cpu_wr = 1'b1; a.cpu_adr = 32'h60; a.cpu_wdata = 32'h77;
    cyc();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_mem_wr", 32'(a.mem_wr), 0);
    chk("arst_mem_rd", 32'(a.mem_rd), 0);
    chk("arst_mem_adr", a.mem_adr, 0);
    chk("arst_mem_wdata", a.mem_wdata, 0);
    chk("arst_ext_rdata", a.ext_rdata, 0);
    chk("arst_cpu_stall", 32'(a.cpu_stall), 1);
    cyc();
    chk("arst_mem_wr_held", 32'(a.mem_wr), 0);
    chk("arst_word_kept", mem[8'h60], 0);
    rst_n = 1'b1;
    cpu_op(1'b1, 32'h60, 32'h77, st, nwr, nrd, rd);
    chk("post_rst_stall", 32'(st), 2);
    chk("post_rst_wr_pulses", 32'(nwr), 1);
    chk("post_rst_word", mem[8'h60], 32'h77);
    b.cpu_rd = 1'b1; b.cpu_adr = 32'h10;
    #1;
    st = 0; nrd = 0;
    while (b.cpu_stall && st < 20) begin
      nrd += int'(b.mem_rd);
      st++;
      cyc();
    end
    nrd += int'(b.mem_rd);
    rd = b.cpu_rdata;
    b.cpu_rd = 1'b0;
    cyc();
    chk("lat1_stall_cycles", 32'(st), 1);
    chk("lat1_rd_cycles", 32'(nrd), 1);
    chk("lat1_rdata", rd, 32'hDEADBEEF);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
